// File: rtl/huffman_encoder.sv
// Huffman encoder: 5-bit symbols -> MSB-first packed 32-bit words via a 32-entry codebook.
// Define ENC_STATS_EN to add the sym_count / bit_count statistics outputs.
module huffman_encoder #(
  parameter int SYM_W  = 5,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LEN_W+SYM_W+CODE_W-1:0] codebook_data,
  input  logic                          WVALID,
  output logic                          WREADY,
  input  logic                          encode,
  input  logic                          flush,
  input  logic [SYM_W-1:0]              sym,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  output logic [CODE_W-1:0]             data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LEN_W-1:0]              out_bits,
  output logic                          out_last,
  output logic                          done,
`ifdef ENC_STATS_EN
  output logic [31:0]                   sym_count,
  output logic [31:0]                   bit_count,
`endif
  output logic                          err
);

  localparam int ACC_W = 2 * CODE_W;
  localparam int NSYM  = 1 << SYM_W;
  localparam int FW    = LEN_W + 1;

  localparam logic [FW-1:0]    FULL      = FW'(CODE_W);
  localparam logic [LEN_W-1:0] FULL_BITS = LEN_W'(CODE_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENCODE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_tab  [NSYM];
  logic [CODE_W-1:0] code_tab [NSYM];
  logic [ACC_W-1:0]  acc;
  logic [FW-1:0]     fill;

  logic [LEN_W-1:0]  wr_len;
  logic [SYM_W-1:0]  wr_src;
  logic [CODE_W-1:0] wr_code;
  logic              wr_fire;

  assign wr_len  = codebook_data[LEN_W+SYM_W+CODE_W-1 -: LEN_W];
  assign wr_src  = codebook_data[CODE_W +: SYM_W];
  assign wr_code = codebook_data[CODE_W-1:0];

  assign WREADY  = rst && (state == IDLE);
  assign wr_fire = WVALID && WREADY;

  logic [LEN_W-1:0]  cur_len;
  logic [FW-1:0]     eff_len;
  logic [CODE_W-1:0] code_mask;
  logic [CODE_W-1:0] code_bits;
  logic              sym_fire;
  logic              out_free;
  logic              full_emit;
  logic              last_emit;
  logic [FW-1:0]     fill_base;
  logic [ACC_W-1:0]  acc_shift;
  logic [ACC_W-1:0]  ins;
  logic [ACC_W-1:0]  acc_nxt;
  logic [FW-1:0]     fill_nxt;
  logic [CODE_W-1:0] tail_mask;

  // Over-long lengths are clamped so fill never exceeds the accumulator
  always_comb begin
    cur_len = len_tab[sym];
    eff_len = ({1'b0, cur_len} > FULL) ? FULL : {1'b0, cur_len};
  end

  assign code_mask = ~({CODE_W{1'b1}} >> eff_len);
  assign code_bits = code_tab[sym] & code_mask;

  assign sym_ready = (state == ENCODE) && !flush && (fill <= FULL);
  assign sym_fire  = sym_valid && sym_ready;
  assign out_free  = !out_valid || out_ready;

  assign full_emit = out_free && (fill >= FULL) &&
                     ((state == ENCODE) || (state == FLUSH));
  assign last_emit = out_free && (state == FLUSH) && (fill < FULL);

  // Shift out the emitted word first, then append behind what remains
  always_comb begin
    fill_base = full_emit ? (fill - FULL) : fill;
    acc_shift = full_emit ? {acc[CODE_W-1:0], {CODE_W{1'b0}}} : acc;
    ins       = {code_bits, {CODE_W{1'b0}}} >> fill_base;
    acc_nxt   = sym_fire ? (acc_shift | ins) : acc_shift;
    fill_nxt  = fill_base + (sym_fire ? eff_len : '0);
  end

  assign tail_mask = ~({CODE_W{1'b1}} >> fill);
  assign done      = (state == DONE) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSYM; i++) len_tab[i] <= '0;
    end else if (wr_fire) begin
      len_tab[wr_src] <= wr_len;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) code_tab[wr_src] <= wr_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:   if (encode) state <= ENCODE;
        ENCODE: if (flush) state <= FLUSH;
        FLUSH:  if (last_emit) state <= DONE;
        DONE:   if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if ((state == IDLE) && encode) err <= 1'b0;
      else if (sym_fire && (cur_len == '0)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      fill <= '0;
    end else if (last_emit) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      out_bits  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (full_emit) begin
      data      <= acc[ACC_W-1 -: CODE_W];
      out_bits  <= FULL_BITS;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
    end else if (last_emit) begin
      data      <= acc[ACC_W-1 -: CODE_W] & tail_mask;
      out_bits  <= fill[LEN_W-1:0];
      out_last  <= 1'b1;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ENC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= '0;
      bit_count <= '0;
    end else if ((state == IDLE) && encode) begin
      sym_count <= '0;
      bit_count <= '0;
    end else if (sym_fire) begin
      sym_count <= sym_count + 32'd1;
      bit_count <= bit_count + 32'(eff_len);
    end
  end
`endif

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Compresses a stream of 5-bit source symbols into MSB-first Huffman-coded 32-bit words, using a 32-entry codebook indexed by symbol.
- Its output word stream is the input format the Huffman decoder consumes: codes packed big-endian and contiguous across word boundaries, final word zero-padded.
- Sits between the symbol producer (quantiser / weight source) and compressed-data storage.

Parameters:
- SYM_W, 5, symbol width; the codebook has 2^SYM_W entries.
- CODE_W, 32, maximum code length and output word width.
- LEN_W, 6, width of the length field.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- codebook_data  input  43  entry fields: [42:37] length, [36:32] source, [31:0] code, left-aligned (code in bits 31..32-length).
- WVALID  input  1  codebook entry valid.
- WREADY  output  1  codebook entry accepted this cycle when WVALID&&WREADY.
- encode  input  1  start encoding; sampled in IDLE.
- flush  input  1  end of stream; sampled in ENCODE.
- sym  input  5  source symbol.
- sym_valid  input  1  symbol valid.
- sym_ready  output  1  symbol accepted when sym_valid&&sym_ready.
- data  output  32  packed output word, MSB first.
- out_valid  output  1  data valid.
- out_ready  input  1  downstream accepts the word.
- out_bits  output  6  valid bits in data: 32 for full words, 0..31 for the last word.
- out_last  output  1  marks the final word of the stream.
- done  output  1  one-cycle pulse when the last word is accepted.
- err  output  1  sticky flag: an unprogrammed symbol (length 0) was seen; cleared on IDLE->ENCODE.

Behaviour:
- Reset: all outputs 0, data=0, state IDLE, all codebook lengths cleared to 0, accumulator and fill count cleared. Reset acts immediately, including mid-stream; any partial word is discarded.
- States:
  - IDLE -> ENCODE on encode=1.
  - ENCODE -> FLUSH on flush=1.
  - FLUSH -> DONE once the last word is loaded into the output register.
  - DONE -> IDLE when the last word is accepted; done pulses in that cycle.
- Codebook writes:
  - WREADY=1 only in IDLE.
  - On a handshake, the entry is written at index codebook_data[36:32]. Entries are not filled sequentially; a later write to the same source overwrites.
  - WVALID outside IDLE is ignored (WREADY=0).
- Accumulator: 64 bits, with fill count 0..64. Bit 63 is the oldest bit.
- Symbol accept:
  - sym_ready = (state==ENCODE) && !flush && fill<=32.
  - On accept, the code's top len bits are written at accumulator positions 63-fill down to 64-fill-len; fill += len. Bits appear one cycle after the handshake.
  - len=0: symbol consumed, no bits, err<=1.
- Word emit:
  - When the output register is empty (or being accepted this cycle) and fill>=32: data<=acc[63:32], out_bits<=32, out_valid<=1; accumulator shifts left 32; fill -= 32.
  - Accept and emit in the same cycle: shift first, then append at position 63-(fill-32). Net fill = fill+len-32.
- Output hold: data, out_bits and out_last are stable while out_valid && !out_ready. Full-throughput operation sustains one word per cycle.
- FLUSH:
  - sym_ready=0. Drain all full words first.
  - Then emit the terminating word: data = acc[63:32] with bits below out_bits zero; out_bits=fill; out_last=1.
  - If fill=0, the terminating word is 0 with out_bits=0.
- Symbol-to-word latency: a word whose last bit arrives at handshake cycle N shows out_valid at N+2 when the output register is free.

Optional Feature:
- ENC_STATS_EN.
- Defined: adds outputs sym_count[31:0] (symbols accepted) and bit_count[31:0] (code bits appended). Both clear on IDLE->ENCODE and wrap modulo 2^32.
- Undefined: these ports and their counters are absent.

Test Plan:
- Load sym0=len1 code 32'h0, sym1=len2 32'h80000000, sym2=len2 32'hC0000000; encode 0,1,2,0; flush -> one word data=32'h58000000, out_bits=6, out_last=1, then done pulse.
- Same codebook, 16× sym1, flush -> 32'hAAAAAAAA (out_bits=32, out_last=0), then 32'h0 (out_bits=0, out_last=1).
- sym3=len32 code 32'hFFFFFFFF; out_ready=0; feed sym3 repeatedly -> exactly three accepted, then sym_ready=0; data stays 32'hFFFFFFFF; raising out_ready resumes one word per cycle.
- Encode unprogrammed sym 31 between sym0s -> err=1, no bits added; next encode clears err.
- WVALID asserted during ENCODE -> WREADY stays 0 and the table is unchanged; rst low mid-stream -> out_valid=0, state IDLE, all lengths 0.
- ENC_STATS_EN defined, first scenario -> sym_count=4, bit_count=6.
